// File: rtl/pll_lock_reset_sequencer.sv
// pll_lock_reset_sequencer: drives PLL areset, qualifies lock, then releases peripheral and core resets in order.
// Retries failed lock attempts up to MAX_RETRIES before latching FAULT; soft_restart or reset recovers.
module pll_lock_reset_sequencer #(
    parameter int AREST_HOLD_CYCLES   = 127,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP_CYCLES  = 16,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       soft_restart,
    output logic       pll_areset,
    output logic       periph_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_count
);
    localparam int MAX_AB  = AREST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES ? AREST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD  = LOCK_STABLE_CYCLES > RELEASE_GAP_CYCLES ? LOCK_STABLE_CYCLES : RELEASE_GAP_CYCLES;
    localparam int CNT_MAX = MAX_AB > MAX_CD ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(AREST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(RELEASE_GAP_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {HOLD, WAIT_LOCK, STABLE, REL_PERIPH, RUN, FAULT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_areset_q, pll_areset_d;
    logic                   periph_reset_q, periph_reset_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        sync_d      = {sync_q[SYNC_STAGES-2:0], pll_locked};
        if (soft_restart) begin
            state_d = HOLD;
            retry_d = '0;
        end else begin
            case (state_q)
                HOLD:       if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = (retry_q + 4'd1 == RETRY_MAX) ? FAULT : HOLD;
                        retry_d = retry_q + 4'd1;
                    end
                end
                STABLE: begin
                    if (!locked_s) state_d = WAIT_LOCK;
                    else if (cnt_q == STABLE_LAST) state_d = REL_PERIPH;
                end
                REL_PERIPH: begin
                    if (!locked_s) begin
                        state_d = HOLD;
                    end else if (cnt_q == GAP_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d     = HOLD;
                        lock_lost_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Count restarts on every state change and on soft_restart; idle in RUN/FAULT.
        cnt_d = (soft_restart || state_d != state_q || state_q inside {RUN, FAULT}) ? '0 : cnt_q + 1'b1;
        pll_areset_d   = state_d inside {HOLD, FAULT};
        periph_reset_d = !(state_d inside {REL_PERIPH, RUN});
        sys_reset_d    = state_d != RUN;
        ready_d        = state_d == RUN;
        fault_d        = state_d == FAULT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HOLD;
            cnt_q          <= '0;
            retry_q        <= '0;
            sync_q         <= '0;
            pll_areset_q   <= 1'b1;
            periph_reset_q <= 1'b1;
            sys_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
            fault_q        <= 1'b0;
            lock_lost_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            sync_q         <= sync_d;
            pll_areset_q   <= pll_areset_d;
            periph_reset_q <= periph_reset_d;
            sys_reset_q    <= sys_reset_d;
            ready_q        <= ready_d;
            fault_q        <= fault_d;
            lock_lost_q    <= lock_lost_d;
        end
    end

    assign pll_areset   = pll_areset_q;
    assign periph_reset = periph_reset_q;
    assign sys_reset    = sys_reset_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign lock_lost    = lock_lost_q;
    assign retry_count  = retry_q;
endmodule
